// File: rtl/lc3b_types.sv
// Shared LC-3b types: victim-cache sequencing states and geometry.
package lc3b_types;

  localparam int VC_WAYS  = 8;
  localparam int VC_IDX_W = 3;

  typedef enum logic [3:0] {
    INIT     = 4'd0,
    IDLE     = 4'd1,
    LOOKUP   = 4'd2,
    HIT_RESP = 4'd3,
    FETCH    = 4'd4,
    SELECT   = 4'd5,
    WB       = 4'd6,
    INSERT   = 4'd7,
    RESP_W   = 4'd8
  } vc_state_t;

endpackage

// File: rtl/vc_control_way_select.sv
// Lowest-index priority encoder: returns the index of the lowest set bit and a found flag.
module vc_way_select #(
  parameter int WAYS  = 8,
  parameter int IDX_W = 3
) (
  input  logic [WAYS-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan high to low so the lowest set bit is the last assignment.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_control.sv
// Victim-cache sequencer between L2 and physical memory: lookups, insertions,
// dirty write-backs and the post-reset invalidation sweep.
//
// state    | meaning
// ---------+----------------------------------------------------
// INIT     | sweep counter walks every way, writing invalid/clean
// IDLE     | wait for an L2 request (write beats read)
// LOOKUP   | read: register the hitting way or go fetch
// HIT_RESP | return VC line to L2 and invalidate the entry
// FETCH    | read miss: pmem read, resp follows pmem_resp
// SELECT   | write: choose hit / free / LRU way as target
// WB       | write back the dirty target to pmem
// INSERT   | write the victim line into the target way
// RESP_W   | acknowledge the insertion to L2
module vc_control
  import lc3b_types::*;
#(
  parameter int WAYS  = VC_WAYS,
  parameter int IDX_W = VC_IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             l2_vc_read,
  input  logic             l2_vc_write,
  input  logic             l2_victim_dirty,
  output logic             l2_vc_resp,
  output logic             l2_vc_hit,
  output logic             l2_line_dirty,
  input  logic [WAYS-1:0]  way_hit,
  input  logic [WAYS-1:0]  way_valid,
  input  logic [WAYS-1:0]  way_dirty,
  input  logic [IDX_W-1:0] lru_way,
  output logic [IDX_W-1:0] data_index,
  output logic             load_vc,
  output logic             load_vc_dirty,
  output logic             valid_in,
  output logic             dirty_in,
  output logic             load_lru,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp
);

  vc_state_t        state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             op_write_q, op_write_d;

  logic [IDX_W-1:0] hit_idx, free_idx, target_idx;
  logic             hit_found, free_found;

  vc_way_select #(.WAYS(WAYS), .IDX_W(IDX_W)) u_hit_sel (
    .vec   (way_valid & way_hit),
    .idx   (hit_idx),
    .found (hit_found)
  );

  vc_way_select #(.WAYS(WAYS), .IDX_W(IDX_W)) u_free_sel (
    .vec   (~way_valid),
    .idx   (free_idx),
    .found (free_found)
  );

  always_comb begin
    target_idx = lru_way;
    if (hit_found) begin
      target_idx = hit_idx;
    end else if (free_found) begin
      target_idx = free_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      op_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      op_write_q <= op_write_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    op_write_d    = op_write_q;
    l2_vc_resp    = 1'b0;
    l2_vc_hit     = 1'b0;
    l2_line_dirty = 1'b0;
    data_index    = idx_q;
    load_vc       = 1'b0;
    load_vc_dirty = 1'b0;
    valid_in      = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;

    unique case (state_q)
      INIT: begin
        data_index    = cnt_q;
        load_vc       = 1'b1;
        load_vc_dirty = 1'b1;
        cnt_d         = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(WAYS - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (l2_vc_write) begin
          op_write_d = 1'b1;
          state_d    = SELECT;
        end else if (l2_vc_read) begin
          op_write_d = 1'b0;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_found) begin
          idx_d   = hit_idx;
          state_d = HIT_RESP;
        end else begin
          state_d = FETCH;
        end
      end
      HIT_RESP: begin
        l2_vc_resp    = 1'b1;
        l2_vc_hit     = 1'b1;
        l2_line_dirty = way_dirty[idx_q];
        // The line migrates to L2, so the entry is freed on the way out.
        load_vc       = 1'b1;
        load_vc_dirty = 1'b1;
        state_d       = IDLE;
      end
      FETCH: begin
        pmem_read  = 1'b1;
        l2_vc_resp = pmem_resp & ~op_write_q;
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      SELECT: begin
        idx_d = target_idx;
        if (way_valid[target_idx] && way_dirty[target_idx] && !hit_found) begin
          state_d = WB;
        end else begin
          state_d = INSERT;
        end
      end
      WB: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          state_d = INSERT;
        end
      end
      INSERT: begin
        load_vc       = 1'b1;
        load_vc_dirty = 1'b1;
        load_lru      = 1'b1;
        valid_in      = 1'b1;
        dirty_in      = l2_victim_dirty;
        state_d       = RESP_W;
      end
      RESP_W: begin
        l2_vc_resp = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase

    // Everything is quiet while reset is held, including the INIT decode.
    if (!reset_n) begin
      l2_vc_resp    = 1'b0;
      l2_vc_hit     = 1'b0;
      l2_line_dirty = 1'b0;
      data_index    = '0;
      load_vc       = 1'b0;
      load_vc_dirty = 1'b0;
      valid_in      = 1'b0;
      dirty_in      = 1'b0;
      load_lru      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
    end
  end

endmodule

// File: tb/tb_vc_control.sv
// Directed bench for vc_control: init sweep, read hit/miss, clean/dirty inserts, priority, reset abort.
module tb_vc_control;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       l2_vc_read, l2_vc_write, l2_victim_dirty;
  logic       l2_vc_resp, l2_vc_hit, l2_line_dirty;
  logic [7:0] way_hit, way_valid, way_dirty;
  logic [2:0] lru_way, data_index;
  logic       load_vc, load_vc_dirty, valid_in, dirty_in, load_lru;
  logic       pmem_read, pmem_write, pmem_resp;

  int checks = 0;
  int errors = 0;

  vc_control dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .l2_vc_read      (l2_vc_read),
    .l2_vc_write     (l2_vc_write),
    .l2_victim_dirty (l2_victim_dirty),
    .l2_vc_resp      (l2_vc_resp),
    .l2_vc_hit       (l2_vc_hit),
    .l2_line_dirty   (l2_line_dirty),
    .way_hit         (way_hit),
    .way_valid       (way_valid),
    .way_dirty       (way_dirty),
    .lru_way         (lru_way),
    .data_index      (data_index),
    .load_vc         (load_vc),
    .load_vc_dirty   (load_vc_dirty),
    .valid_in        (valid_in),
    .dirty_in        (dirty_in),
    .load_lru        (load_lru),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    l2_vc_read = 0; l2_vc_write = 0; l2_victim_dirty = 0;
    way_hit = 8'h20; way_valid = 8'h20; way_dirty = 8'h20; lru_way = 3'd0;
    pmem_resp = 0;
    #12;
    check("rst_load_vc", {7'd0, load_vc}, 8'd0);
    check("rst_index", {5'd0, data_index}, 8'd0);
    check("rst_resp", {7'd0, l2_vc_resp}, 8'd0);
    tick();
    reset_n = 1'b1;
    #1;

    // Init sweep; a read raised mid-sweep must wait
    for (int i = 0; i < 8; i++) begin
      if (i == 2) l2_vc_read = 1'b1;
      check($sformatf("init_idx%0d", i), {5'd0, data_index}, 8'(i));
      check($sformatf("init_ld%0d", i), {6'd0, load_vc, load_vc_dirty}, 8'd3);
      check($sformatf("init_vin%0d", i), {6'd0, valid_in, dirty_in}, 8'd0);
      check($sformatf("init_resp%0d", i), {7'd0, l2_vc_resp}, 8'd0);
      tick();
    end

    // Read hit on way 5 (IDLE now, sampled this cycle)
    check("idle_resp", {7'd0, l2_vc_resp}, 8'd0);
    tick();
    check("lookup_resp", {7'd0, l2_vc_resp}, 8'd0);
    tick();
    check("hit_resp", {5'd0, l2_vc_resp, l2_vc_hit, l2_line_dirty}, 8'd7);
    check("hit_idx", {5'd0, data_index}, 8'd5);
    check("hit_inval", {4'd0, load_vc, load_vc_dirty, valid_in, dirty_in}, 8'b1100);
    l2_vc_read = 0;
    tick();
    check("hit_done", {7'd0, l2_vc_resp}, 8'd0);

    // Read miss
    way_hit = 8'h00;
    l2_vc_read = 1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fetch_hold%0d", i), {6'd0, pmem_read, l2_vc_resp}, 8'b10);
      tick();
    end
    pmem_resp = 1;
    #1;
    check("fetch_resp", {5'd0, pmem_read, l2_vc_resp, l2_vc_hit}, 8'b110);
    check("fetch_noload", {7'd0, load_vc}, 8'd0);
    tick();
    pmem_resp = 0; l2_vc_read = 0;
    check("fetch_done", {6'd0, pmem_read, l2_vc_resp}, 8'd0);

    // Stray pmem_resp in IDLE is ignored
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    check("stray_resp", {5'd0, l2_vc_resp, pmem_read, pmem_write}, 8'd0);

    // Clean insert into free way 3
    way_valid = 8'hF7; way_dirty = 8'h00; l2_vc_write = 1;
    tick(); tick();
    check("ins3_idx", {5'd0, data_index}, 8'd3);
    check("ins3_ctl", {3'd0, load_vc, load_lru, valid_in, dirty_in, pmem_write}, 8'b11100);
    tick();
    check("ins3_resp", {6'd0, l2_vc_resp, l2_vc_hit}, 8'b10);
    l2_vc_write = 0;
    tick();

    // Dirty LRU victim needs write-back first
    way_valid = 8'hFF; way_dirty = 8'h04; lru_way = 3'd2; l2_victim_dirty = 1; l2_vc_write = 1;
    tick(); tick();
    check("wb_start", {4'd0, pmem_write, data_index}, 8'b1010);
    tick(); tick();
    check("wb_hold", {4'd0, pmem_write, data_index}, 8'b1010);
    pmem_resp = 1;
    #1;
    check("wb_noresp", {7'd0, l2_vc_resp}, 8'd0);
    tick();
    pmem_resp = 0;
    check("wb_ins", {2'd0, pmem_write, load_vc, load_lru, valid_in, dirty_in, 1'b0}, 8'b011110);
    check("wb_ins_idx", {5'd0, data_index}, 8'd2);
    tick();
    check("wb_respw", {6'd0, l2_vc_resp, l2_vc_hit}, 8'b10);
    l2_vc_write = 0; l2_victim_dirty = 0;
    tick();

    // Write beats read; all valid and clean -> LRU way 6, no traffic
    way_dirty = 8'h00; lru_way = 3'd6; l2_vc_read = 1; l2_vc_write = 1;
    tick();
    check("both_sel", {6'd0, pmem_read, pmem_write}, 8'd0);
    tick();
    check("both_ins", {4'd0, load_lru, data_index}, 8'b1110);
    tick();
    check("both_respw", {6'd0, l2_vc_resp, l2_vc_hit}, 8'b10);
    l2_vc_write = 0;
    tick(); tick(); tick();
    check("both_fetch", {6'd0, pmem_read, l2_vc_resp}, 8'b10);
    pmem_resp = 1;
    #1;
    check("both_fetch_resp", {7'd0, l2_vc_resp}, 8'd1);
    tick();
    pmem_resp = 0; l2_vc_read = 0;
    tick();

    // Reset during write-back aborts the handshake
    way_dirty = 8'h01; lru_way = 3'd0; l2_vc_write = 1;
    tick(); tick();
    check("abort_wb", {7'd0, pmem_write}, 8'd1);
    reset_n = 0;
    #1;
    check("abort_drop", {6'd0, pmem_write, l2_vc_resp}, 8'd0);
    l2_vc_write = 0;
    tick();
    reset_n = 1;
    #1;
    check("abort_init", {4'd0, load_vc, data_index}, 8'b1000);
    tick();
    check("abort_init1", {5'd0, data_index}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
